// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache controller
module dcache_controller #(
    parameter int INDEX_W = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);
    localparam int TAG_W = 8 - INDEX_W - 2;
    localparam int NBLK  = 2 ** INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t state, next_state;
    logic   seen_busy, seen_busy_next;
    logic   capture_req;

    logic [NBLK-1:0]    valid;
    logic [NBLK-1:0]    dirty;
    logic [TAG_W-1:0]   tags   [NBLK];
    logic [31:0]        blocks [NBLK];
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_index;
    logic [1:0]         addr_off;
    logic               req, hit, store_hit;

    assign addr_tag   = ADDRESS[7 -: TAG_W];
    assign addr_index = ADDRESS[2 +: INDEX_W];
    assign addr_off   = ADDRESS[1:0];
    assign req        = READ | WRITE;
    assign hit        = valid[addr_index] && (tags[addr_index] == addr_tag);
    // WRITE wins over READ, so any request with WRITE high is a store
    assign store_hit  = (state == IDLE) && WRITE && hit;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            seen_busy <= 1'b0;
            req_tag   <= '0;
            req_index <= '0;
        end else begin
            state     <= next_state;
            seen_busy <= seen_busy_next;
            if (capture_req) begin
                req_tag   <= addr_tag;
                req_index <= addr_index;
            end
        end
    end

    always_comb begin
        next_state     = state;
        seen_busy_next = seen_busy;
        capture_req    = 1'b0;
        BUSYWAIT       = 1'b0;
        MEM_READ       = 1'b0;
        MEM_WRITE      = 1'b0;
        MEM_ADDRESS    = '0;
        MEM_WRITEDATA  = '0;
        READDATA       = '0;
        // Outputs are forced quiet while reset is held, independent of inputs
        if (RESET) begin
            case (state)
                IDLE: begin
                    READDATA = blocks[addr_index][{addr_off, 3'b000} +: 8];
                    BUSYWAIT = req && !hit;
                    if (req && !hit) begin
                        capture_req = 1'b1;
                        next_state  = dirty[addr_index] ? WRITEBACK : FETCH;
                    end
                end
                WRITEBACK: begin
                    BUSYWAIT       = 1'b1;
                    MEM_WRITE      = 1'b1;
                    MEM_ADDRESS    = {tags[req_index], req_index};
                    MEM_WRITEDATA  = blocks[req_index];
                    seen_busy_next = seen_busy | MEM_BUSYWAIT;
                    if (!MEM_BUSYWAIT && seen_busy) begin
                        seen_busy_next = 1'b0;
                        next_state     = FETCH;
                    end
                end
                FETCH: begin
                    BUSYWAIT       = 1'b1;
                    MEM_READ       = 1'b1;
                    MEM_ADDRESS    = {req_tag, req_index};
                    seen_busy_next = seen_busy | MEM_BUSYWAIT;
                    if (!MEM_BUSYWAIT && seen_busy) begin
                        seen_busy_next = 1'b0;
                        next_state     = UPDATE;
                    end
                end
                UPDATE: begin
                    BUSYWAIT   = 1'b1;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Single write port: a hit store and a refill never occur in the same cycle
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
            dirty <= '0;
            for (int i = 0; i < NBLK; i++) begin
                tags[i]   <= '0;
                blocks[i] <= '0;
            end
        end else if (state == UPDATE) begin
            blocks[req_index] <= MEM_READDATA;
            tags[req_index]   <= req_tag;
            valid[req_index]  <= 1'b1;
            dirty[req_index]  <= 1'b0;
        end else if (store_hit) begin
            blocks[addr_index][{addr_off, 3'b000} +: 8] <= WRITEDATA;
            dirty[addr_index] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench for dcache_controller
module tb_dcache_controller;
    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    dcache_controller dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Block memory behind the cache
    logic [31:0] mem_arr [64];
    logic        mem_active;
    logic        mem_is_wr;
    logic [5:0]  mem_a;
    logic [31:0] mem_wd;
    int          mem_cnt, mem_lat;
    int          wb_cnt, fetch_cnt, both_err;
    logic [5:0]  last_wb_addr, last_fetch_addr;
    logic [31:0] last_wb_data;

    // Reference model: the cache seen as tag/valid/dirty/data per set over its own memory copy
    logic        m_valid [8];
    logic        m_dirty [8];
    int          m_tag   [8];
    logic [31:0] m_data  [8];
    logic [31:0] model_mem [64];

    function automatic logic [31:0] init_word(input int i);
        return 32'h1F2E3D4C ^ (32'(i) * 32'h01050301);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic model_access(input logic wr, input logic [7:0] a, input logic [7:0] d,
                                output logic hit, output logic wb, output logic [7:0] rd);
        int idx, tg, off;
        idx = int'(a[4:2]);
        tg  = int'(a[7:5]);
        off = int'(a[1:0]);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        wb  = 1'b0;
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                model_mem[m_tag[idx] * 8 + idx] = m_data[idx];
                wb = 1'b1;
            end
            m_data[idx]  = model_mem[tg * 8 + idx];
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        rd = m_data[idx][off * 8 +: 8];
        if (wr) begin
            m_data[idx][off * 8 +: 8] = d;
            m_dirty[idx] = 1'b1;
        end
    endtask

    // Holds MEM_BUSYWAIT high for mem_lat posedges, then completes the access
    task automatic mem_responder();
        forever begin
            @(negedge CLK);
            if (MEM_READ === 1'b1 && MEM_WRITE === 1'b1) both_err++;
            if (!mem_active) begin
                if (MEM_READ === 1'b1 || MEM_WRITE === 1'b1) begin
                    mem_active   = 1'b1;
                    mem_is_wr    = MEM_WRITE;
                    mem_a        = MEM_ADDRESS;
                    mem_wd       = MEM_WRITEDATA;
                    mem_cnt      = mem_lat;
                    MEM_BUSYWAIT = 1'b1;
                    if (MEM_WRITE) begin
                        wb_cnt++;
                        last_wb_addr = MEM_ADDRESS;
                        last_wb_data = MEM_WRITEDATA;
                    end else begin
                        fetch_cnt++;
                        last_fetch_addr = MEM_ADDRESS;
                    end
                end
            end else begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    if (mem_is_wr) mem_arr[mem_a] = mem_wd;
                    else           MEM_READDATA   = mem_arr[mem_a];
                    MEM_BUSYWAIT = 1'b0;
                    mem_active   = 1'b0;
                end
            end
        end
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rdata, output logic missed, output logic timeout);
        int cyc;
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
        #1;
        missed  = BUSYWAIT;
        cyc     = 0;
        timeout = 1'b0;
        while (BUSYWAIT !== 1'b0 && cyc < 200) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        if (cyc >= 200) timeout = 1'b1;
        rdata = READDATA;
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        #1 RESET = 1'b0;
        #2;
        n_checks++;
        if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000 || READDATA !== 8'h00 || MEM_ADDRESS !== 6'd0 || MEM_WRITEDATA !== 32'd0)
            $display("FAIL reset_outputs: busy/rd/wr=%b%b%b readdata=%h addr=%h wdata=%h, required all zero",
                     BUSYWAIT, MEM_READ, MEM_WRITE, READDATA, MEM_ADDRESS, MEM_WRITEDATA);
        else n_pass++;
        READ = 1'b1; ADDRESS = 8'h08;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0) $display("FAIL reset_busy_with_req: BUSYWAIT=%b, required 0", BUSYWAIT);
        else n_pass++;
        READ = 1'b0;
        #2 RESET = 1'b1;
        model_reset();
    endtask

    task automatic test_cold_store();
        logic [7:0] rd, erd; logic missed, to, eh, ewb; int w0, f0;
        w0 = wb_cnt; f0 = fetch_cnt;
        model_access(1'b1, 8'h08, 8'h0A, eh, ewb, erd);
        do_op(1'b0, 1'b1, 8'h08, 8'h0A, rd, missed, to);
        n_checks++;
        if (missed !== 1'b1 || to !== 1'b0) $display("FAIL cold_store_miss: busy=%b timeout=%b, required 1 0", missed, to);
        else n_pass++;
        n_checks++;
        if (fetch_cnt - f0 != 1 || last_fetch_addr !== 6'b000010)
            $display("FAIL cold_store_fetch: fetches=%0d addr=%b, required 1 000010", fetch_cnt - f0, last_fetch_addr);
        else n_pass++;
        n_checks++;
        if (wb_cnt != w0) $display("FAIL cold_store_no_wb: writebacks=%0d, required 0", wb_cnt - w0);
        else n_pass++;
        w0 = wb_cnt; f0 = fetch_cnt;
        model_access(1'b0, 8'h08, 8'h00, eh, ewb, erd);
        do_op(1'b1, 1'b0, 8'h08, 8'h00, rd, missed, to);
        n_checks++;
        if (missed !== 1'b0 || rd !== 8'h0A || erd !== 8'h0A)
            $display("FAIL load_hit_0x08: busy=%b data=%h, required 0 0a", missed, rd);
        else n_pass++;
        n_checks++;
        if (wb_cnt != w0 || fetch_cnt != f0) $display("FAIL load_hit_mem_idle: mem ops=%0d, required 0", wb_cnt - w0 + fetch_cnt - f0);
        else n_pass++;
    endtask

    task automatic test_dirty_conflict();
        logic [7:0] rd, erd; logic missed, to, eh, ewb; int w0, f0;
        w0 = wb_cnt; f0 = fetch_cnt;
        model_access(1'b1, 8'h28, 8'h05, eh, ewb, erd);
        do_op(1'b0, 1'b1, 8'h28, 8'h05, rd, missed, to);
        n_checks++;
        if (wb_cnt - w0 != 1 || last_wb_addr !== 6'b000010 || last_wb_data[7:0] !== 8'h0A)
            $display("FAIL conflict_wb: n=%0d addr=%b byte0=%h, required 1 000010 0a", wb_cnt - w0, last_wb_addr, last_wb_data[7:0]);
        else n_pass++;
        n_checks++;
        if (fetch_cnt - f0 != 1 || last_fetch_addr !== 6'b001010)
            $display("FAIL conflict_fetch: n=%0d addr=%b, required 1 001010", fetch_cnt - f0, last_fetch_addr);
        else n_pass++;
        n_checks++;
        if (mem_arr[2][7:0] !== 8'h0A) $display("FAIL conflict_mem_byte8: got %h, required 0a", mem_arr[2][7:0]);
        else n_pass++;
        model_access(1'b0, 8'h28, 8'h00, eh, ewb, erd);
        do_op(1'b1, 1'b0, 8'h28, 8'h00, rd, missed, to);
        n_checks++;
        if (missed !== 1'b0 || rd !== erd || rd !== 8'h05)
            $display("FAIL conflict_load_back: busy=%b data=%h, required 0 05", missed, rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        logic [7:0] rd, erd; logic missed, to, eh, ewb; int cyc;
        mem_lat = 5;
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h44;
        cyc = 0;
        do begin
            @(negedge CLK); #1; cyc++;
        end while (!(MEM_READ === 1'b1 && MEM_BUSYWAIT === 1'b1) && cyc < 50);
        n_checks++;
        if (cyc >= 50) $display("FAIL midfetch_reach: fetch never observed, required within 50 cycles");
        else n_pass++;
        #1 RESET = 1'b0;
        #1;
        n_checks++;
        if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0 || MEM_WRITE !== 1'b0)
            $display("FAIL midfetch_async: mem_read=%b busy=%b mem_write=%b, required 0 0 0", MEM_READ, BUSYWAIT, MEM_WRITE);
        else n_pass++;
        @(negedge CLK);
        RESET = 1'b1; READ = 1'b0;
        model_reset();
        cyc = 0;
        while (mem_active && cyc < 50) begin @(negedge CLK); cyc++; end
        mem_lat = 2;
        model_access(1'b0, 8'h44, 8'h00, eh, ewb, erd);
        do_op(1'b1, 1'b0, 8'h44, 8'h00, rd, missed, to);
        n_checks++;
        if (missed !== 1'b1 || rd !== erd) $display("FAIL midfetch_reload: busy=%b data=%h, required 1 %h", missed, rd, erd);
        else n_pass++;
        model_access(1'b0, 8'h08, 8'h00, eh, ewb, erd);
        do_op(1'b1, 1'b0, 8'h08, 8'h00, rd, missed, to);
        n_checks++;
        if (missed !== 1'b1 || rd !== 8'h0A) $display("FAIL after_reset_0x08: busy=%b data=%h, required 1 0a", missed, rd);
        else n_pass++;
    endtask

    task automatic test_read_write_both();
        logic [7:0] rd, erd; logic missed, to, eh, ewb; int w0;
        model_access(1'b1, 8'h08, 8'h33, eh, ewb, erd);
        do_op(1'b1, 1'b1, 8'h08, 8'h33, rd, missed, to);
        n_checks++;
        if (missed !== 1'b0) $display("FAIL both_hit: busy=%b, required 0", missed);
        else n_pass++;
        model_access(1'b0, 8'h08, 8'h00, eh, ewb, erd);
        do_op(1'b1, 1'b0, 8'h08, 8'h00, rd, missed, to);
        n_checks++;
        if (rd !== 8'h33) $display("FAIL both_store_data: got %h, required 33", rd);
        else n_pass++;
        w0 = wb_cnt;
        model_access(1'b0, 8'h28, 8'h00, eh, ewb, erd);
        do_op(1'b1, 1'b0, 8'h28, 8'h00, rd, missed, to);
        n_checks++;
        if (wb_cnt - w0 != 1 || last_wb_data[7:0] !== 8'h33 || rd !== erd)
            $display("FAIL both_dirty_wb: n=%0d byte0=%h data=%h, required 1 33 %h", wb_cnt - w0, last_wb_data[7:0], rd, erd);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] rd, erd, a, d; logic missed, to, eh, ewb; int w0, f0, kind;
        for (int n = 0; n < 80; n++) begin
            mem_lat = int'($urandom_range(1, 3));
            kind = int'($urandom_range(0, 2));
            a = {$urandom_range(0, 3) == 0 ? 3'd4 : 3'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 2'($urandom)};
            d = 8'($urandom);
            w0 = wb_cnt; f0 = fetch_cnt;
            model_access(kind != 0, a, d, eh, ewb, erd);
            do_op(kind != 1, kind != 0, a, d, rd, missed, to);
            n_checks++;
            if (missed !== !eh || to !== 1'b0 || fetch_cnt - f0 != (eh ? 0 : 1))
                $display("FAIL rand_hit[%0d] addr=%h: busy=%b timeout=%b fetches=%0d, required busy %b", n, a, missed, to, fetch_cnt - f0, !eh);
            else n_pass++;
            n_checks++;
            if (wb_cnt - w0 != (ewb ? 1 : 0))
                $display("FAIL rand_wb[%0d] addr=%h: writebacks=%0d, required %0d", n, a, wb_cnt - w0, ewb ? 1 : 0);
            else n_pass++;
            if (kind == 0) begin
                n_checks++;
                if (rd !== erd) $display("FAIL rand_load[%0d] addr=%h: got %h, required %h", n, a, rd, erd);
                else n_pass++;
            end
        end
    endtask

    task automatic test_final();
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem_arr[i] !== model_mem[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL memory_image: %0d blocks differ, required 0", bad);
        else n_pass++;
        n_checks++;
        if (both_err != 0) $display("FAIL read_write_exclusive: %0d overlapping cycles, required 0", both_err);
        else n_pass++;
    endtask

    initial begin
        READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00; RESET = 1'b1;
        MEM_READDATA = 32'd0; MEM_BUSYWAIT = 1'b0;
        mem_active = 1'b0; mem_is_wr = 1'b0; mem_a = 6'd0; mem_wd = 32'd0; mem_cnt = 0; mem_lat = 2;
        wb_cnt = 0; fetch_cnt = 0; both_err = 0;
        last_wb_addr = 6'd0; last_fetch_addr = 6'd0; last_wb_data = 32'd0;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i]   = init_word(i);
            model_mem[i] = init_word(i);
        end
        for (int i = 0; i < 8; i++) begin
            m_tag[i]  = 0;
            m_data[i] = 32'd0;
        end
        fork
            mem_responder();
        join_none
        test_reset();
        test_cold_store();
        test_dirty_conflict();
        test_reset_mid_fetch();
        test_read_write_both();
        test_random();
        test_final();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store port and the block-wide data memory.
- Hits are served with no stall; misses stall the CPU via BUSYWAIT while the controller sequences write-back and refill.
- Storage (tag/valid/dirty arrays, data blocks) is internal; the FSM owns all memory-side handshakes.

Parameters:
- INDEX_W, 3, index bits; number of blocks = 2**INDEX_W (8).
- Fixed geometry: 8-bit byte address = {tag[7-INDEX_W-2+1..], index, offset[1:0]}.
- Block size: 4 bytes. Tag width: 8-INDEX_W-2 (3 at default).

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  CPU byte address.
- WRITEDATA  in  8  CPU store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  block read request.
- MEM_WRITE  out  1  block write request.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  victim block, byte0 in [7:0].
- MEM_READDATA  in  32  refill block, byte0 in [7:0].
- MEM_BUSYWAIT  in  1  memory busy.

Behaviour:
- Reset (RESET=0, async):
  - All valid and dirty bits cleared; state=IDLE; seen_busy=0.
  - Outputs held at BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, READDATA=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
- Request decode:
  - req = READ|WRITE. WRITE has priority if both are asserted (treated as a store).
  - hit = valid[index] && tag[index]==ADDRESS tag field.
- IDLE:
  - BUSYWAIT = req && !hit (combinational).
  - Read hit: READDATA = selected byte combinationally, BUSYWAIT=0, zero stall.
  - Write hit: byte written at next posedge; dirty[index] set; BUSYWAIT=0.
  - Miss: on posedge, capture req_tag and req_index.
    - dirty[index]=1 -> WRITEBACK.
    - otherwise -> FETCH.
  - No request: no state change; READDATA reflects the indexed byte (don't-care).
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag, req_index}, MEM_WRITEDATA=victim block; BUSYWAIT=1.
  - seen_busy is set on the first posedge with MEM_BUSYWAIT=1.
  - Exit -> FETCH on the first posedge with MEM_BUSYWAIT=0 and seen_busy=1; seen_busy cleared on exit.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS={req_tag, req_index}; BUSYWAIT=1.
  - Same seen_busy handshake as WRITEBACK; exit -> UPDATE.
- UPDATE (1 cycle):
  - Block <= MEM_READDATA, tag <= req_tag, valid=1, dirty=0; BUSYWAIT=1.
  - MEM_READ/MEM_WRITE=0.
  - Next state IDLE; the held request then hits and completes in IDLE.
- MEM_READ and MEM_WRITE are never both 1, and both are deasserted in IDLE and UPDATE.
- The CPU holds READ/WRITE/ADDRESS/WRITEDATA stable while BUSYWAIT=1. The controller uses the captured req_tag/req_index for memory addressing regardless.
- If req drops while in WRITEBACK/FETCH, the sequence still completes; the block is installed and no CPU write occurs.
- Reset mid-operation: the FSM returns to IDLE immediately; the in-flight memory request is dropped and no block is installed. The memory may complete the dropped access harmlessly.
- Clean eviction performs no WRITEBACK.
- Single-port arrays: at most one block write per cycle (hit store or refill).

Test Plan:
- Reset pulse low 5 ns -> BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0; all valid=0.
- Store 0x0A to 0x08 after reset (cold, clean miss):
  - BUSYWAIT rises combinationally; FETCH issues MEM_ADDRESS=6'b000010; no MEM_WRITE.
  - After refill and UPDATE, the write hits; dirty[2]=1, byte0 of block2=0x0A; BUSYWAIT falls.
- Load from 0x08 immediately after -> hit: BUSYWAIT stays 0, READDATA=0x0A in the same cycle, no memory activity.
- Store 0x05 to 0x28 (same index 2, tag 001, dirty conflict):
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS=6'b000010, MEM_WRITEDATA[7:0]=0x0A.
  - Then FETCH: MEM_ADDRESS=6'b001010.
  - End state: tag[2]=001, dirty=1, byte0=0x05.
  - Memory byte 0x08 reads back 0x0A.
- Assert RESET during FETCH while MEM_BUSYWAIT=1 -> MEM_READ=0 and BUSYWAIT=0 asynchronously. After release, a load from the same address misses again (valid=0).
- READ and WRITE both high on a hit to 0x08 with WRITEDATA=0x33 -> treated as a store: byte becomes 0x33 and the dirty bit is set.
